// File: rtl/fnd_scan_to_bcd.sv
// FND scan receiver: snoops digit-select/font lines and rebuilds {d3,d2,d1,d0} BCD frames.
// Ports: i_clk, i_reset_n, i_digit, i_fndfont, i_clear -> o_bcd, o_valid, o_frame_err, o_sel_err [, o_dp with FND_DP_CAPTURE_EN].
module fnd_scan_to_bcd #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [3:0]  i_digit,
  input  logic [7:0]  i_fndfont,
  input  logic        i_clear,
`ifdef FND_DP_CAPTURE_EN
  output logic [3:0]  o_dp,
`endif
  output logic [15:0] o_bcd,
  output logic        o_valid,
  output logic        o_frame_err,
  output logic        o_sel_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_HOLD
  } state_t;

  localparam logic [7:0] ACC = 8'(DEBOUNCE_CNT - 1);

  state_t      state, state_n;
  logic [3:0]  r_digit, p_digit;
  logic [7:0]  r_font, p_font;
  logic [7:0]  cnt, cnt_n, cnt_inc;
  logic [3:0]  seen, seen_n;
  logic [3:0]  err, err_n;
  logic [15:0] shadow;
  logic [1:0]  idx;
  logic        sel_ok, sel_multi;
  logic [3:0]  nib;
  logic        bad;
  logic        same, accept, commit;
  logic [7:0]  font_in;

`ifdef FND_DP_CAPTURE_EN
  logic [3:0]  shadow_dp;
  assign font_in = i_fndfont;
`else
  // dp forced off so it never affects pair comparison
  assign font_in = i_fndfont | 8'h80;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_digit <= 4'hF;
      r_font  <= 8'hFF;
      p_digit <= 4'hF;
      p_font  <= 8'hFF;
    end else begin
      r_digit <= i_digit;
      r_font  <= font_in;
      p_digit <= r_digit;
      p_font  <= r_font;
    end
  end

  always_comb begin
    idx       = 2'd0;
    sel_ok    = 1'b0;
    sel_multi = 1'b0;
    case (r_digit)
      4'b1110: begin idx = 2'd0; sel_ok = 1'b1; end
      4'b1101: begin idx = 2'd1; sel_ok = 1'b1; end
      4'b1011: begin idx = 2'd2; sel_ok = 1'b1; end
      4'b0111: begin idx = 2'd3; sel_ok = 1'b1; end
      4'b1111: sel_ok = 1'b0;
      default: sel_multi = 1'b1;
    endcase
  end

  always_comb begin
    nib = 4'hE;
    bad = 1'b0;
    case (r_font[6:0])
      7'h40: nib = 4'd0;
      7'h79: nib = 4'd1;
      7'h24: nib = 4'd2;
      7'h30: nib = 4'd3;
      7'h19: nib = 4'd4;
      7'h12: nib = 4'd5;
      7'h02: nib = 4'd6;
      7'h78: nib = 4'd7;
      7'h00: nib = 4'd8;
      7'h10: nib = 4'd9;
      7'h7F: nib = 4'hF;
      default: bad = 1'b1;
    endcase
  end

  assign same    = (r_digit == p_digit) && (r_font == p_font);
  assign cnt_inc = cnt + 8'd1;
  assign commit  = (seen == 4'b1111);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sel_ok) begin
          state_n = S_DWELL;
          cnt_n   = 8'd0;
        end
      end
      S_DWELL: begin
        if (!sel_ok) begin
          state_n = S_IDLE;
        end else if (!same) begin
          cnt_n = 8'd0;
        end else if (cnt_inc == ACC) begin
          accept  = 1'b1;
          state_n = S_HOLD;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_HOLD: begin
        if (!sel_ok) begin
          state_n = S_IDLE;
        end else if (!same) begin
          state_n = S_DWELL;
          cnt_n   = 8'd0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // an accept on the commit edge starts the next frame
  always_comb begin
    seen_n = commit ? 4'b0000 : seen;
    err_n  = commit ? 4'b0000 : err;
    if (accept) begin
      seen_n[idx] = 1'b1;
      err_n[idx]  = bad;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else if (i_clear) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      seen        <= 4'b0000;
      err         <= 4'b0000;
      shadow      <= 16'h0000;
      o_bcd       <= 16'h0000;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_sel_err   <= 1'b0;
`ifdef FND_DP_CAPTURE_EN
      shadow_dp   <= 4'h0;
      o_dp        <= 4'h0;
`endif
    end else if (i_clear) begin
      seen        <= 4'b0000;
      err         <= 4'b0000;
      shadow      <= 16'h0000;
      o_valid     <= 1'b0;
      o_sel_err   <= 1'b0;
`ifdef FND_DP_CAPTURE_EN
      shadow_dp   <= 4'h0;
`endif
    end else begin
      seen    <= seen_n;
      err     <= err_n;
      o_valid <= commit;
      if (sel_multi) o_sel_err <= 1'b1;
      if (accept) begin
        shadow[{idx, 2'b00} +: 4] <= nib;
`ifdef FND_DP_CAPTURE_EN
        shadow_dp[idx] <= ~r_font[7];
`endif
      end
      if (commit) begin
        o_bcd       <= shadow;
        o_frame_err <= |err;
`ifdef FND_DP_CAPTURE_EN
        o_dp        <= shadow_dp;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_to_bcd.sv
// Directed bench for fnd_scan_to_bcd.
// Drives scan patterns on negedge, checks frame results captured on o_valid.
module tb_fnd_scan_to_bcd;

  logic        clk;
  logic        rst_n;
  logic [3:0]  digit;
  logic [7:0]  font;
  logic        clear;
  logic [15:0] bcd;
  logic        valid;
  logic        ferr;
  logic        serr;
`ifdef FND_DP_CAPTURE_EN
  logic [3:0]  dp;
`endif

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  logic [15:0] last_bcd = 16'h0;
  logic        last_ferr = 1'b0;

  fnd_scan_to_bcd #(.DEBOUNCE_CNT(4)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_digit     (digit),
    .i_fndfont   (font),
    .i_clear     (clear),
`ifdef FND_DP_CAPTURE_EN
    .o_dp        (dp),
`endif
    .o_bcd       (bcd),
    .o_valid     (valid),
    .o_frame_err (ferr),
    .o_sel_err   (serr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (valid) begin
      vcnt      = vcnt + 1;
      last_bcd  = bcd;
      last_ferr = ferr;
    end
  end

  task automatic drive(input logic [3:0] d, input logic [7:0] f, input int n);
    digit = d;
    font  = f;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3);
    drive(4'b1110, f0, 8);
    drive(4'b1101, f1, 8);
    drive(4'b1011, f2, 8);
    drive(4'b0111, f3, 8);
    drive(4'b1111, 8'hFF, 4);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    digit = 4'hF;
    font  = 8'hFF;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bcd !== 16'h0000) begin
      errors++; $display("FAIL reset_bcd got %h exp 0000", bcd);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", valid);
    end
    checks++;
    if (ferr !== 1'b0) begin
      errors++; $display("FAIL reset_ferr got %b exp 0", ferr);
    end
    checks++;
    if (serr !== 1'b0) begin
      errors++; $display("FAIL reset_serr got %b exp 0", serr);
    end
  endtask

  task automatic test_basic;
    vcnt = 0;
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99);
    checks++;
    if (vcnt !== 1) begin
      errors++; $display("FAIL basic_vcnt got %0d exp 1", vcnt);
    end
    checks++;
    if (last_bcd !== 16'h4321) begin
      errors++; $display("FAIL basic_bcd got %h exp 4321", last_bcd);
    end
    checks++;
    if (last_ferr !== 1'b0) begin
      errors++; $display("FAIL basic_ferr got %b exp 0", last_ferr);
    end
  endtask

  task automatic test_glitch;
    vcnt = 0;
    drive(4'b1110, 8'h99, 8);
    drive(4'b1101, 8'h92, 8);
    drive(4'b1011, 8'hA4, 2);
    drive(4'b1011, 8'hA5, 2);
    drive(4'b1011, 8'hA4, 8);
    drive(4'b0111, 8'h82, 8);
    drive(4'b1111, 8'hFF, 4);
    checks++;
    if (vcnt !== 1) begin
      errors++; $display("FAIL glitch_vcnt got %0d exp 1", vcnt);
    end
    checks++;
    if (last_bcd !== 16'h6254) begin
      errors++; $display("FAIL glitch_bcd got %h exp 6254", last_bcd);
    end
    checks++;
    if (last_ferr !== 1'b0) begin
      errors++; $display("FAIL glitch_ferr got %b exp 0", last_ferr);
    end
  endtask

  task automatic test_bad_font;
    vcnt = 0;
    scan4(8'hC0, 8'hAA, 8'hA4, 8'hB0);
    checks++;
    if (vcnt !== 1) begin
      errors++; $display("FAIL badfont_vcnt got %0d exp 1", vcnt);
    end
    checks++;
    if (last_bcd !== 16'h32E0) begin
      errors++; $display("FAIL badfont_bcd got %h exp 32e0", last_bcd);
    end
    checks++;
    if (last_ferr !== 1'b1) begin
      errors++; $display("FAIL badfont_ferr got %b exp 1", last_ferr);
    end
  endtask

  task automatic test_sel_err;
    vcnt = 0;
    drive(4'b1100, 8'hC0, 6);
    drive(4'b1111, 8'hFF, 4);
    checks++;
    if (serr !== 1'b1) begin
      errors++; $display("FAIL selerr_set got %b exp 1", serr);
    end
    checks++;
    if (vcnt !== 0) begin
      errors++; $display("FAIL selerr_nocap got %0d exp 0", vcnt);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (serr !== 1'b0) begin
      errors++; $display("FAIL selerr_clr got %b exp 0", serr);
    end
  endtask

  task automatic test_clear;
    vcnt = 0;
    drive(4'b1110, 8'h92, 8);
    drive(4'b1101, 8'h82, 8);
    drive(4'b1011, 8'hF8, 8);
    drive(4'b1111, 8'hFF, 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (bcd !== 16'h32E0) begin
      errors++; $display("FAIL clear_keep got %h exp 32e0", bcd);
    end
    scan4(8'h90, 8'h80, 8'hF8, 8'h82);
    checks++;
    if (vcnt !== 1) begin
      errors++; $display("FAIL clear_vcnt got %0d exp 1", vcnt);
    end
    checks++;
    if (last_bcd !== 16'h6789) begin
      errors++; $display("FAIL clear_bcd got %h exp 6789", last_bcd);
    end
  endtask

  task automatic test_reset_mid;
    vcnt = 0;
    drive(4'b1110, 8'h92, 8);
    drive(4'b1100, 8'hC0, 3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bcd !== 16'h0000) begin
      errors++; $display("FAIL rstmid_bcd got %h exp 0000", bcd);
    end
    checks++;
    if (serr !== 1'b0) begin
      errors++; $display("FAIL rstmid_serr got %b exp 0", serr);
    end
    checks++;
    if (valid !== 1'b0 || ferr !== 1'b0) begin
      errors++; $display("FAIL rstmid_vf got %b%b exp 00", valid, ferr);
    end
    digit = 4'hF;
    font  = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(4'b1101, 8'hC0, 8);
    drive(4'b1011, 8'hF9, 8);
    drive(4'b0111, 8'hB0, 8);
    drive(4'b1111, 8'hFF, 4);
    checks++;
    if (vcnt !== 0) begin
      errors++; $display("FAIL rstmid_discard got %0d exp 0", vcnt);
    end
    drive(4'b1110, 8'h80, 8);
    drive(4'b1111, 8'hFF, 4);
    checks++;
    if (vcnt !== 1) begin
      errors++; $display("FAIL rstmid_vcnt got %0d exp 1", vcnt);
    end
    checks++;
    if (last_bcd !== 16'h3108) begin
      errors++; $display("FAIL rstmid_bcd2 got %h exp 3108", last_bcd);
    end
    checks++;
    if (last_ferr !== 1'b0) begin
      errors++; $display("FAIL rstmid_ferr got %b exp 0", last_ferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_bad_font();
    test_sel_err();
    test_clear();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
